dma_desc_scheduler: RTL and testbench

Multi-channel descriptor scheduler sitting between user DMA command sources and one descriptor-bypass port of the PCIe DMA engine (instantiated once for C2H, once for H2C). It accepts (address, length) commands from NUM_CH requesters and arbitrates among them round-robin. Each command is split into descriptors that never exceed MAX_DESC_LEN bytes and never cross a MAX_DESC_LEN-aligned boundary. Descriptors are issued on the bypass ready/load handshake, and a per-channel done pulse is raised when a command's last descriptor has been loaded.

---
 rtl/dma_desc_scheduler_pkg.sv | 19 +
 rtl/dma_desc_scheduler_if.sv | 30 +++
 rtl/dma_desc_scheduler_rr_arbiter.sv | 45 ++++
 rtl/dma_desc_scheduler.sv | 139 +++++++++++++
 tb/tb_dma_desc_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_desc_scheduler_pkg.sv
// Shared types for the descriptor scheduler: FSM states and the bypass descriptor.
// The descriptor carries a full 64-bit address and is narrowed to ADDR_W at the port.
package dma_pkg;

  localparam int DSC_LEN_W  = 28;
  localparam int DSC_ADDR_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPLIT = 2'd1,
    ST_ISSUE = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [DSC_ADDR_W-1:0] addr;
    logic [DSC_LEN_W-1:0]  len;
  } desc_t;

endpackage

// File: rtl/dma_desc_scheduler_if.sv
// Command sources plus descriptor-bypass port; slave is the scheduler, master drives commands/ready.
// Per-channel command fields are packed: channel i occupies [i*W +: W].
interface dma_desc_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 32
) ();
  import dma_pkg::*;

  logic [NUM_CH-1:0]        cmd_valid;
  logic [NUM_CH-1:0]        cmd_ready;
  logic [NUM_CH*ADDR_W-1:0] cmd_addr;
  logic [NUM_CH*LEN_W-1:0]  cmd_len;
  logic [NUM_CH-1:0]        cmd_done;
  logic                     dsc_byp_ready;
  logic                     dsc_byp_load;
  logic [ADDR_W-1:0]        dsc_byp_addr;
  logic [DSC_LEN_W-1:0]     dsc_byp_len;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, dsc_byp_ready,
    output cmd_ready, cmd_done, dsc_byp_load, dsc_byp_addr, dsc_byp_len
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, dsc_byp_ready,
    input  cmd_ready, cmd_done, dsc_byp_load, dsc_byp_addr, dsc_byp_len
  );

endinterface

// File: rtl/dma_desc_scheduler_rr_arbiter.sv
// Round-robin arbiter: zero-latency grant searching from the channel after the last accepted one.
// The pointer moves only on accept, so an unaccepted grant stays put while the owner stalls.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              accept,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  localparam int IW = CH_W + 1;

  logic [CH_W-1:0] ptr_q;
  logic [IW-1:0]   idx;
  logic            found;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, ptr_q} + IW'(i);
      if (idx >= IW'(NUM_CH)) idx = idx - IW'(NUM_CH);
      if (!found && req[idx[CH_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = idx[CH_W-1:0];
      end
    end
  end

  assign grant = found ? (NUM_CH'(1) << grant_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept && found) begin
      ptr_q <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

endmodule

// File: rtl/dma_desc_scheduler.sv
// Splits round-robin-arbitrated (addr,len) commands into aligned bypass descriptors; first load 2 cycles after accept, then one per cycle.
// Holds the descriptor while dsc_byp_ready is low; DMA_DESC_SCHED_STATS_EN adds desc_count/byte_count.
module dma_desc_scheduler
  import dma_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int ADDR_W       = 64,
  parameter int LEN_W        = 32,
  parameter int MAX_DESC_LEN = 4096
) (
  input  logic                 pcie_clk,
  input  logic                 pcie_aresetn,
  dma_desc_scheduler_if.slave  bus,
  output logic                 busy
`ifdef DMA_DESC_SCHED_STATS_EN
  ,
  output logic [31:0]          desc_count,
  output logic [47:0]          byte_count
`endif
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OFF_W = $clog2(MAX_DESC_LEN);
  localparam int CW    = (LEN_W > DSC_LEN_W) ? LEN_W : DSC_LEN_W;

  sched_state_t         state_q, state_d;
  logic [CH_W-1:0]      cur_ch_q, cur_ch_d, grant_idx;
  logic [ADDR_W-1:0]    cur_addr_q, cur_addr_d, addr_step, sel_addr;
  logic [LEN_W-1:0]     rem_q, rem_d, rem_step, chunk_rem, sel_len;
  logic [OFF_W-1:0]     chunk_off;
  logic [DSC_LEN_W-1:0] space, chunk;
  logic [CW-1:0]        rem_cmp, space_cmp;
  desc_t                dsc_q, dsc_d;
  logic [NUM_CH-1:0]    grant, done_q, done_d;
  logic                 accept, load;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clk       (pcie_clk),
    .rst_n     (pcie_aresetn),
    .req       (bus.cmd_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept   = (state_q == ST_IDLE) && (|grant);
  assign sel_addr = bus.cmd_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_len  = bus.cmd_len[grant_idx*LEN_W +: LEN_W];
  assign load     = (state_q == ST_ISSUE) && bus.dsc_byp_ready;

  assign addr_step = cur_addr_q + ADDR_W'(dsc_q.len);
  assign rem_step  = rem_q - LEN_W'(dsc_q.len);

  // In ISSUE the next chunk is derived from the post-load position so back-to-back loads need no SPLIT.
  assign chunk_off = (state_q == ST_ISSUE) ? addr_step[OFF_W-1:0] : cur_addr_q[OFF_W-1:0];
  assign chunk_rem = (state_q == ST_ISSUE) ? rem_step : rem_q;
  assign space     = DSC_LEN_W'(MAX_DESC_LEN) - DSC_LEN_W'(chunk_off);
  assign rem_cmp   = CW'(chunk_rem);
  assign space_cmp = CW'(space);
  assign chunk     = (rem_cmp < space_cmp) ? DSC_LEN_W'(rem_cmp) : space;

  always_comb begin
    state_d    = state_q;
    cur_ch_d   = cur_ch_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    dsc_d      = dsc_q;
    done_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cur_ch_d   = grant_idx;
          cur_addr_d = sel_addr;
          rem_d      = sel_len;
          if (sel_len == '0) done_d  = grant;
          else               state_d = ST_SPLIT;
        end
      end
      ST_SPLIT: begin
        dsc_d   = '{addr: DSC_ADDR_W'(cur_addr_q), len: chunk};
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (load) begin
          cur_addr_d = addr_step;
          rem_d      = rem_step;
          if (rem_step == '0) begin
            done_d[cur_ch_q] = 1'b1;
            state_d          = ST_IDLE;
          end else begin
            dsc_d = '{addr: DSC_ADDR_W'(addr_step), len: chunk};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) begin
      state_q    <= ST_IDLE;
      cur_ch_q   <= '0;
      cur_addr_q <= '0;
      rem_q      <= '0;
      dsc_q      <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_ch_q   <= cur_ch_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      dsc_q      <= dsc_d;
      done_q     <= done_d;
    end
  end

  assign bus.cmd_ready    = (state_q == ST_IDLE) ? grant : '0;
  assign bus.cmd_done     = done_q;
  assign bus.dsc_byp_load = load;
  assign bus.dsc_byp_addr = dsc_q.addr[ADDR_W-1:0];
  assign bus.dsc_byp_len  = dsc_q.len;
  assign busy             = (state_q != ST_IDLE);

`ifdef DMA_DESC_SCHED_STATS_EN
  always_ff @(posedge pcie_clk or negedge pcie_aresetn) begin
    if (!pcie_aresetn) begin
      desc_count <= '0;
      byte_count <= '0;
    end else if (load) begin
      desc_count <= desc_count + 32'd1;
      byte_count <= byte_count + 48'(dsc_q.len);
    end
  end
`endif

endmodule

// File: tb/tb_dma_desc_scheduler.sv
// Directed bench for dma_desc_scheduler: scoreboard queues for grants, descriptors and done pulses.
// A negedge monitor pops the queues; the directed steps check cycle timing and held outputs.
module tb_dma_desc_scheduler;
  import dma_pkg::*;

  localparam int NUM_CH       = 4;
  localparam int ADDR_W       = 64;
  localparam int LEN_W        = 32;
  localparam int MAX_DESC_LEN = 4096;

  typedef struct packed {
    logic [63:0] addr;
    logic [27:0] len;
  } exp_dsc_t;

  logic pcie_clk     = 1'b0;
  logic pcie_aresetn = 1'b0;
  logic busy;
`ifdef DMA_DESC_SCHED_STATS_EN
  logic [31:0] desc_count;
  logic [47:0] byte_count;
`endif

  dma_desc_scheduler_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  dma_desc_scheduler #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_DESC_LEN(MAX_DESC_LEN)
  ) dut (
    .pcie_clk     (pcie_clk),
    .pcie_aresetn (pcie_aresetn),
    .bus          (bus),
    .busy         (busy)
`ifdef DMA_DESC_SCHED_STATS_EN
    ,
    .desc_count   (desc_count),
    .byte_count   (byte_count)
`endif
  );

  always #5 pcie_clk = ~pcie_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_dsc_t exp_dsc_q[$];
  int       exp_done_q[$];
  int       exp_grant_q[$];
  int       load_cyc[$];
  int       done_cyc[$];
  int       hs_cyc[$];
  exp_dsc_t e;

  always @(posedge pcie_clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    load_cyc.delete();
    done_cyc.delete();
    hs_cyc.delete();
  endtask

  task automatic set_cmd(input int ch, input logic [63:0] addr, input logic [31:0] len);
    bus.cmd_addr[ch*ADDR_W +: ADDR_W] = addr;
    bus.cmd_len[ch*LEN_W +: LEN_W]    = len;
  endtask

  // Raise valid on mask, drop each channel after its handshake (ch0 optionally kept for one extra grant).
  task automatic run_grants(input logic [NUM_CH-1:0] mask, input int n_exp, input bit hold0);
    logic [NUM_CH-1:0] hs;
    int got = 0;
    int n   = 0;
    bit keep = hold0;
    @(posedge pcie_clk); #1;
    bus.cmd_valid = mask;
    while (got < n_exp && n < 200) begin
      @(negedge pcie_clk); #1;
      n++;
      hs = bus.cmd_ready & bus.cmd_valid;
      if (hs != '0) begin
        got++;
        @(posedge pcie_clk); #1;
        if (hs[0] && keep) keep = 1'b0;
        else bus.cmd_valid = bus.cmd_valid & ~hs;
      end
    end
    check("grant_count", got, n_exp);
    bus.cmd_valid = '0;
  endtask

  task automatic send(input int ch, input logic [63:0] addr, input logic [31:0] len);
    set_cmd(ch, addr, len);
    exp_grant_q.push_back(ch);
    run_grants(NUM_CH'(1) << ch, 1, 1'b0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_dsc_q.size() + exp_done_q.size() + exp_grant_q.size()) != 0 && n < 300) begin
      @(negedge pcie_clk); #1;
      n++;
    end
    @(negedge pcie_clk); #1;
    check({tag, "_drain"}, exp_dsc_q.size() + exp_done_q.size() + exp_grant_q.size(), 0);
  endtask

  always @(negedge pcie_clk) begin
    if (pcie_aresetn) begin
      if (bus.dsc_byp_load) begin
        check("load_needs_ready", bus.dsc_byp_ready, 1);
        check("load_expected", exp_dsc_q.size() != 0, 1);
        if (exp_dsc_q.size() != 0) begin
          e = exp_dsc_q.pop_front();
          check("dsc_addr", bus.dsc_byp_addr, e.addr);
          check("dsc_len", bus.dsc_byp_len, e.len);
        end
        load_cyc.push_back(cyc);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.cmd_done[c]) begin
          check("done_expected", exp_done_q.size() != 0, 1);
          if (exp_done_q.size() != 0) check("done_channel", c, exp_done_q.pop_front());
          done_cyc.push_back(cyc);
        end
      end
      if ((bus.cmd_ready & bus.cmd_valid) != '0) begin
        check("hs_onehot", $onehot(bus.cmd_ready & bus.cmd_valid), 1);
        for (int c = 0; c < NUM_CH; c++) begin
          if (bus.cmd_ready[c] && bus.cmd_valid[c]) begin
            check("grant_expected", exp_grant_q.size() != 0, 1);
            if (exp_grant_q.size() != 0) check("grant_order", c, exp_grant_q.pop_front());
          end
        end
        hs_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid     = '0;
    bus.cmd_addr      = '0;
    bus.cmd_len       = '0;
    bus.dsc_byp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge pcie_clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_cmd_done", bus.cmd_done, 0);
    check("rst_load", bus.dsc_byp_load, 0);
    check("rst_addr", bus.dsc_byp_addr, 0);
    check("rst_len", bus.dsc_byp_len, 0);
    check("rst_busy", busy, 0);
`ifdef DMA_DESC_SCHED_STATS_EN
    check("rst_desc_count", desc_count, 0);
    check("rst_byte_count", byte_count, 0);
`endif
    @(posedge pcie_clk); #1;
    pcie_aresetn      = 1'b1;
    bus.dsc_byp_ready = 1'b1;

    // All four channels at once, ch0 held for a second command: grants 0,1,2,3,0
    clear_logs();
    for (int i = 0; i < NUM_CH; i++) set_cmd(i, 64'hABCD_0000_0000_0000 + 64'(i) * 64'h1000, 32'd64);
    for (int i = 0; i < NUM_CH; i++) begin
      exp_grant_q.push_back(i);
      exp_dsc_q.push_back('{addr: 64'hABCD_0000_0000_0000 + 64'(i) * 64'h1000, len: 28'd64});
      exp_done_q.push_back(i);
    end
    exp_grant_q.push_back(0);
    exp_dsc_q.push_back('{addr: 64'hABCD_0000_0000_0000, len: 28'd64});
    exp_done_q.push_back(0);
    run_grants(4'b1111, 5, 1'b1);
    drain("rr");
    check("rr_nloads", load_cyc.size(), 5);
    if (hs_cyc.size() >= 2 && done_cyc.size() >= 1) begin
      check("rr_back_to_back", hs_cyc[1], hs_cyc[0] + 3);
      check("rr_done_with_grant", done_cyc[0], hs_cyc[1]);
    end

    // Two aligned 4 KiB chunks with ready held high
    clear_logs();
    exp_dsc_q.push_back('{addr: 64'h1000, len: 28'd4096});
    exp_dsc_q.push_back('{addr: 64'h2000, len: 28'd4096});
    exp_done_q.push_back(0);
    send(0, 64'h1000, 32'd8192);
    drain("t1");
    check("t1_nloads", load_cyc.size(), 2);
    check("t1_ndone", done_cyc.size(), 1);
    if (load_cyc.size() == 2 && done_cyc.size() == 1 && hs_cyc.size() == 1) begin
      check("t1_first_load", load_cyc[0], hs_cyc[0] + 2);
      check("t1_second_load", load_cyc[1], hs_cyc[0] + 3);
      check("t1_done", done_cyc[0], hs_cyc[0] + 4);
    end

    // Boundary crossing is split
    clear_logs();
    exp_dsc_q.push_back('{addr: 64'h0F00, len: 28'h100});
    exp_dsc_q.push_back('{addr: 64'h1000, len: 28'h200});
    exp_done_q.push_back(1);
    send(1, 64'h0F00, 32'h300);
    drain("t2");
    check("t2_nloads", load_cyc.size(), 2);

    // Ready toggling 1,0,0,1 over a 3-chunk command
    clear_logs();
    exp_dsc_q.push_back('{addr: 64'h3000, len: 28'd4096});
    exp_dsc_q.push_back('{addr: 64'h4000, len: 28'd4096});
    exp_dsc_q.push_back('{addr: 64'h5000, len: 28'd4096});
    exp_done_q.push_back(2);
    send(2, 64'h3000, 32'd12288);
    @(posedge pcie_clk); #1;
    bus.dsc_byp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge pcie_clk); #1;
      bus.dsc_byp_ready = 1'b0;
      @(negedge pcie_clk); #1;
      check("t4_hold_load", bus.dsc_byp_load, 0);
      check("t4_hold_addr", bus.dsc_byp_addr, 64'h4000);
      check("t4_hold_len", bus.dsc_byp_len, 4096);
    end
    @(posedge pcie_clk); #1;
    bus.dsc_byp_ready = 1'b1;
    drain("t4");
    check("t4_nloads", load_cyc.size(), 3);
    if (load_cyc.size() == 3 && done_cyc.size() == 1 && hs_cyc.size() == 1) begin
      check("t4_load0", load_cyc[0], hs_cyc[0] + 2);
      check("t4_load1", load_cyc[1], hs_cyc[0] + 5);
      check("t4_load2", load_cyc[2], hs_cyc[0] + 6);
      check("t4_done", done_cyc[0], hs_cyc[0] + 7);
    end

    // Zero-length command
    clear_logs();
    exp_done_q.push_back(2);
    send(2, 64'h7000, 32'd0);
    drain("t5");
    check("t5_nloads", load_cyc.size(), 0);
    if (done_cyc.size() == 1 && hs_cyc.size() == 1) check("t5_done", done_cyc[0], hs_cyc[0] + 1);

`ifdef DMA_DESC_SCHED_STATS_EN
    check("stats_desc_count", desc_count, 12);
    check("stats_byte_count", byte_count, 21568);
`endif

    // Reset during ISSUE discards the command
    clear_logs();
    bus.dsc_byp_ready = 1'b0;
    send(1, 64'h8000, 32'h3000);
    @(posedge pcie_clk); #1;
    check("t6_busy", busy, 1);
    check("t6_issue_addr", bus.dsc_byp_addr, 64'h8000);
    check("t6_issue_len", bus.dsc_byp_len, 4096);
    pcie_aresetn = 1'b0;
    #1;
    bus.dsc_byp_ready = 1'b1;
    #1;
    check("t6_rst_load", bus.dsc_byp_load, 0);
    check("t6_rst_addr", bus.dsc_byp_addr, 0);
    check("t6_rst_len", bus.dsc_byp_len, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", bus.cmd_done, 0);
`ifdef DMA_DESC_SCHED_STATS_EN
    check("t6_rst_desc_count", desc_count, 0);
    check("t6_rst_byte_count", byte_count, 0);
`endif
    repeat (2) @(posedge pcie_clk);
    #1;
    pcie_aresetn = 1'b1;

    // Pointer restarts at channel 0: ch1 wins over ch3, then ch3 issues normally
    clear_logs();
    set_cmd(1, 64'hA000, 32'd64);
    set_cmd(3, 64'h9000, 32'd100);
    exp_grant_q.push_back(1);
    exp_grant_q.push_back(3);
    exp_dsc_q.push_back('{addr: 64'hA000, len: 28'd64});
    exp_dsc_q.push_back('{addr: 64'h9000, len: 28'd100});
    exp_done_q.push_back(1);
    exp_done_q.push_back(3);
    run_grants(4'b1010, 2, 1'b0);
    drain("t6");
    check("t6_nloads", load_cyc.size(), 2);
`ifdef DMA_DESC_SCHED_STATS_EN
    check("t6_desc_count", desc_count, 2);
    check("t6_byte_count", byte_count, 164);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
